// File: rtl/knight_scan.sv
// knight_scan: parametrised bouncing/wrapping LED scanner with step-rate prescaler
module knight_scan #(
    parameter int WIDTH = 8,
    parameter int BEAM  = 1,
    parameter int DIV_W = 16,
    localparam int PW   = $clog2(WIDTH)
) (
    input  logic             ck,
    input  logic             res,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    pos,
    output logic             dir,
    output logic             tick,
    output logic             turn
);
    localparam logic [PW-1:0]    MAXP = PW'(WIDTH - BEAM);
    localparam logic [WIDTH-1:0] MASK = {{(WIDTH - BEAM){1'b0}}, {BEAM{1'b1}}};
    logic [DIV_W-1:0] cnt;
    logic [PW-1:0]    pos_n;
    logic             step;
    logic             dir_n;
    logic             turn_n;
    // >= rather than == so lowering div below the running count fires at once
    assign step = en && (cnt >= div);
    // position and direction one step ahead under the current mode
    always_comb begin
        pos_n  = pos;
        dir_n  = dir;
        turn_n = 1'b0;
        case (mode)
            2'b00: begin
                turn_n = dir ? (pos == MAXP) : (pos == '0);
                dir_n  = turn_n ? !dir : dir;
                pos_n  = dir_n ? pos + 1'b1 : pos - 1'b1;
            end
            2'b01: begin
                dir_n  = 1'b1;
                turn_n = pos == MAXP;
                pos_n  = turn_n ? '0 : pos + 1'b1;
            end
            2'b10: begin
                dir_n  = 1'b0;
                turn_n = pos == '0;
                pos_n  = turn_n ? MAXP : pos - 1'b1;
            end
            default: ;
        endcase
    end
    // prescaler, scan state and strobes; out is rebuilt from the new pos so they never disagree
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            cnt  <= '0;
            pos  <= '0;
            dir  <= 1'b1;
            out  <= MASK;
            tick <= 1'b0;
            turn <= 1'b0;
        end else begin
            cnt  <= step ? '0 : (en ? cnt + 1'b1 : cnt);
            tick <= step;
            turn <= step && turn_n;
            if (step) begin
                pos <= pos_n;
                dir <= dir_n;
                out <= MASK << pos_n;
            end
        end
    end
endmodule
